// File: rtl/mac_result_collector.sv
// Result buffer for the MAC output: credit-gated issue, circular FIFO and a
// ready/valid output stream with a registered head-of-queue data register.
module mac_result_collector #(
  parameter int DATA_WIDTH = 40,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ok,
  input  logic [DATA_WIDTH-1:0] mac_val,
  input  logic                  mac_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  err_overflow,
  output logic                  err_credit
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_occ;
  logic [CNT_W-1:0]      r_inflight;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_err_overflow;
  logic                  r_err_credit;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_credit_ok;
  logic [CNT_W:0]        w_credit_sum;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;

  // Decrement on a matched result, increment on an issue, never above DEPTH.
  function automatic logic [CNT_W-1:0] inflight_next(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] v;
    v = cur;
    if (dec && (v != '0))
      v = v - CNT_W'(1);
    if (inc && (v != CNT_W'(DEPTH)))
      v = v + CNT_W'(1);
    return v;
  endfunction

  assign w_full       = (r_occ == CNT_W'(DEPTH));
  assign w_empty      = (r_occ == '0);
  assign w_pop        = !w_empty && m_ready;
  assign w_push       = mac_valid && (!w_full || w_pop);
  assign w_drop       = mac_valid && w_full && !w_pop;
  assign w_credit_sum = {1'b0, r_occ} + {1'b0, r_inflight};
  assign w_credit_ok  = (w_credit_sum < (CNT_W + 1)'(DEPTH));
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

  assign issue_ok     = !rst && w_credit_ok;
  assign m_valid      = !w_empty;
  assign m_data       = r_m_data;
  assign occupancy    = r_occ;
  assign err_overflow = r_err_overflow;
  assign err_credit   = r_err_credit;

  // Head register follows the entry that will be at the front after this edge.
  always_comb begin
    w_head_nxt = r_m_data;
    if (w_pop && (r_occ > CNT_W'(1)))
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    else if (w_push && (w_empty || (w_pop && (r_occ == CNT_W'(1)))))
      w_head_nxt = mac_val;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= mac_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_occ          <= '0;
      r_inflight     <= '0;
      r_m_data       <= '0;
      r_err_overflow <= 1'b0;
      r_err_credit   <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push && !w_pop)
        r_occ <= r_occ + CNT_W'(1);
      else if (w_pop && !w_push)
        r_occ <= r_occ - CNT_W'(1);
      r_inflight <= inflight_next(r_inflight, issue_valid, mac_valid);
      r_m_data   <= w_head_nxt;
      if (w_drop)
        r_err_overflow <= 1'b1;
      if ((issue_valid && !w_credit_ok) || (mac_valid && (r_inflight == '0)))
        r_err_credit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: hand-computed flags and counts,
// plus a result queue that follows every value through the FIFO.
module tb_mac_result_collector;
  localparam int DW    = 40;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             issue_valid = 1'b0;
  logic             issue_ok;
  logic [DW-1:0]    mac_val = '0;
  logic             mac_valid = 1'b0;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [CNT_W-1:0] occupancy;
  logic             err_overflow;
  logic             err_credit;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];

  mac_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ok(issue_ok),
    .mac_val(mac_val), .mac_valid(mac_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .occupancy(occupancy), .err_overflow(err_overflow),
    .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; checks the presented head against the queue.
  task automatic step(input logic iv, input logic mv, input logic [DW-1:0] val, input logic rdy);
    issue_valid = iv;
    mac_valid   = mv;
    mac_val     = val;
    m_ready     = rdy;
    check_val("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0)
      check_val("m_data", m_data, exp_q[0]);
    if ((exp_q.size() != 0) && rdy)
      void'(exp_q.pop_front());
    if (mv && (exp_q.size() < DEPTH))
      exp_q.push_back(val);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    mac_valid   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_valid = 1'b0;
    mac_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check_val("rst_ok_hi", issue_ok, 0);
    @(posedge clk);
    #1;
    check_val("rst_mvld", m_valid, 0);
    check_val("rst_occ", occupancy, 0);
    check_val("rst_mdata", m_data, 0);
    check_val("rst_ovf", err_overflow, 0);
    check_val("rst_cred", err_credit, 0);
    check_val("rst_ok_in", issue_ok, 0);
    rst = 1'b0;
    #1;
    check_val("rst_ok_out", issue_ok, 1);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] pipe;
    logic       iv;
    logic       mv;
    int         n_res;

    do_reset();

    // 1: eight issues, eight returns streaming straight through
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0, 1'b0);
      check_val("t1_issue_ok", issue_ok, i < 7);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, DW'(40'h100 + i), 1'b1);
      check_val("t1_ret_ok", issue_ok, i != 0);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    check_val("t1_occ", occupancy, 0);
    check_val("t1_ok_back", issue_ok, 1);
    check_val("t1_cred", err_credit, 0);

    // 2: fill with consumer stalled
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, '0, 1'b0);
    check_val("t2_ok_zero", issue_ok, 0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, DW'(40'h200 + i), 1'b0);
    check_val("t2_occ", occupancy, 8);
    check_val("t2_ovf", err_overflow, 0);
    check_val("t2_ok", issue_ok, 0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // 3: push and pop together while full
    step(1'b0, 1'b1, DW'(40'hA1), 1'b1);
    check_val("t3_occ_a1", occupancy, 8);
    step(1'b0, 1'b1, DW'(40'hA2), 1'b1);
    check_val("t3_occ_a2", occupancy, 8);
    check_val("t3_ovf", err_overflow, 0);
    check_val("t3_cred", err_credit, 1);

    // 4: push while full and stalled is dropped
    step(1'b0, 1'b1, DW'(40'hDEAD), 1'b0);
    check_val("t4_ovf", err_overflow, 1);
    check_val("t4_occ", occupancy, 8);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    check_val("t4_occ_end", occupancy, 0);
    check_val("t4_ovf_sticky", err_overflow, 1);

    // 5a: spurious result with nothing in flight
    do_reset();
    step(1'b0, 1'b1, DW'(40'h55), 1'b1);
    check_val("t5_cred_spur", err_credit, 1);
    check_val("t5_occ_spur", occupancy, 1);
    step(1'b0, 1'b0, '0, 1'b1);
    check_val("t5_occ0", occupancy, 0);
    check_val("t5_ok_held0", issue_ok, 1);

    // 5b: over-issue saturates the in-flight count at DEPTH
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, '0, 1'b0);
    check_val("t5_cred_over", err_credit, 1);
    check_val("t5_ok_over", issue_ok, 0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, DW'(40'h500 + i), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check_val("t5_occ_sat", occupancy, 0);
    check_val("t5_ok_sat", issue_ok, 1);
    check_val("t5_ovf", err_overflow, 0);

    // 6: reset with stored and in-flight results
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, DW'(40'h600 + i), 1'b0);
    check_val("t6_occ5", occupancy, 5);
    check_val("t6_ok", issue_ok, 1);
    check_val("t6_cred_pre", err_credit, 1);
    do_reset();

    // 7: credit-respecting traffic across several pointer wraps
    pipe  = '0;
    n_res = 0;
    for (int i = 0; i < 90; i++) begin
      iv = issue_ok && (i < 60);
      mv = pipe[2];
      pipe = {pipe[1:0], iv};
      step(iv, mv, DW'(40'h3000 + n_res), (i % 7) < 4);
      if (mv)
        n_res++;
    end
    step(1'b0, 1'b0, '0, 1'b1);
    check_val("t7_wraps", n_res > 2 * DEPTH, 1);
    check_val("t7_occ", occupancy, 0);
    check_val("t7_ovf", err_overflow, 0);
    check_val("t7_cred", err_credit, 0);
    check_val("t7_ok", issue_ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
